// File: rtl/asic_wb_capture_pkg.sv
// Shared definitions for the ASIC write-back capture sink.
package asic_wb_capture_pkg;

   // Width of the running checksum and of one data lane folded into it.
   localparam int CHK_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Storage is not reset; only the read data register is.
module capture_ram #(
   parameter int DATA_W = 128,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Registered read port; holds its value when no read is requested.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/asic_wb_capture.sv
// FPGA-side sink for ASIC write-back bursts. Armed per transfer, captures up
// to DEPTH words into RAM, keeps a word count and lane-folded checksum, and
// flags short, overflowing and overlapping bursts.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for burst_start; readout allowed
// CAPTURE | wr_rdy high, accepting words until the last index or an abort
// DONE    | one cycle, burst_done high; readout allowed
module asic_wb_capture
   import asic_wb_capture_pkg::*;
#(
   parameter int DATA_W = 128,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6,
   parameter int CNT_W  = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              burst_start,
   input  logic [CNT_W-1:0]  burst_last,
   input  logic              burst_abort,
   input  logic              wr_val,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_rdy,
   output logic              busy,
   output logic              burst_done,
   output logic [CNT_W-1:0]  word_cnt,
   output logic [CHK_W-1:0]  checksum,
   output logic              len_err,
   output logic              overflow,
   output logic              cmd_err,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_data_vld
);

   state_t            state;
   logic [CNT_W-1:0]  last_idx;
   // One extra bit so the pointer can sit at DEPTH once the RAM is full.
   logic [ADDR_W:0]   wr_ptr;
   logic [CHK_W-1:0]  lane_xor;
   logic [CNT_W:0]    cnt_next;
   logic [CNT_W:0]    burst_len;
   logic              xfer;
   logic              is_last;
   logic              ram_we;
   logic              rd_en;

   assign xfer      = wr_val & wr_rdy;
   assign is_last   = xfer && (word_cnt == last_idx);
   assign ram_we    = xfer && !wr_ptr[ADDR_W];
   assign rd_en     = rd_req && (state != ST_CAPTURE);
   assign cnt_next  = {1'b0, word_cnt} + (CNT_W+1)'(xfer);
   assign burst_len = {1'b0, last_idx} + (CNT_W+1)'(1);

   // XOR-fold the data word into one checksum lane.
   always_comb begin
      lane_xor = '0;
      for (int i = 0; i < DATA_W / CHK_W; i++)
         lane_xor = lane_xor ^ wr_data[CHK_W*i +: CHK_W];
   end

   // Burst FSM with registered handshake, status and error outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         last_idx    <= '0;
         wr_ptr      <= '0;
         wr_rdy      <= 1'b0;
         busy        <= 1'b0;
         burst_done  <= 1'b0;
         word_cnt    <= '0;
         checksum    <= '0;
         len_err     <= 1'b0;
         overflow    <= 1'b0;
         cmd_err     <= 1'b0;
         rd_data_vld <= 1'b0;
      end else begin
         rd_data_vld <= rd_en;
         case (state)
            ST_IDLE: begin
               if (burst_start) begin
                  state    <= ST_CAPTURE;
                  busy     <= 1'b1;
                  wr_rdy   <= 1'b1;
                  last_idx <= burst_last;
                  word_cnt <= '0;
                  checksum <= '0;
                  wr_ptr   <= '0;
                  len_err  <= 1'b0;
                  overflow <= 1'b0;
               end
            end
            ST_CAPTURE: begin
               if (burst_start) cmd_err <= 1'b1;
               if (xfer) begin
                  word_cnt <= word_cnt + CNT_W'(1);
                  checksum <= checksum + lane_xor;
                  if (wr_ptr[ADDR_W]) overflow <= 1'b1;
                  else                wr_ptr   <= wr_ptr + (ADDR_W+1)'(1);
               end
               if (is_last || burst_abort) begin
                  state      <= ST_DONE;
                  busy       <= 1'b0;
                  wr_rdy     <= 1'b0;
                  burst_done <= 1'b1;
                  // An abort landing on the last word is a normal end.
                  if (!is_last) len_err <= (cnt_next < burst_len);
               end
            end
            ST_DONE: begin
               if (burst_start) cmd_err <= 1'b1;
               state      <= ST_IDLE;
               burst_done <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   capture_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (ram_we),
      .waddr (wr_ptr[ADDR_W-1:0]),
      .wdata (wr_data),
      .re    (rd_en),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_asic_wb_capture.sv
// Directed bench for asic_wb_capture: full, throttled, overflowing, aborted,
// overlapping and reset-interrupted bursts plus RAM readout.
module tb_asic_wb_capture;

   localparam int DATA_W = 128;
   localparam int ADDR_W = 6;
   localparam int CNT_W  = 10;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              burst_start;
   logic [CNT_W-1:0]  burst_last;
   logic              burst_abort;
   logic              wr_val;
   logic [DATA_W-1:0] wr_data;
   logic              wr_rdy;
   logic              busy;
   logic              burst_done;
   logic [CNT_W-1:0]  word_cnt;
   logic [31:0]       checksum;
   logic              len_err;
   logic              overflow;
   logic              cmd_err;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_data_vld;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   asic_wb_capture dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .burst_start (burst_start),
      .burst_last  (burst_last),
      .burst_abort (burst_abort),
      .wr_val      (wr_val),
      .wr_data     (wr_data),
      .wr_rdy      (wr_rdy),
      .busy        (busy),
      .burst_done  (burst_done),
      .word_cnt    (word_cnt),
      .checksum    (checksum),
      .len_err     (len_err),
      .overflow    (overflow),
      .cmd_err     (cmd_err),
      .rd_req      (rd_req),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_data_vld (rd_data_vld)
   );

   // Plain words carry the index in lane 0; wide words put fixed patterns in
   // lanes 1-3 so the lane fold (lane3^lane2^lane1 = 32'hEF00FF00) matters.
   function automatic logic [DATA_W-1:0] word_of(input int i, input bit wide);
      logic [DATA_W-1:0] w;
      w = DATA_W'(i);
      if (wide) w = {32'hFFFF_0000, 32'h00FF_FF00, 32'h1000_0000, 32'(i)};
      return w;
   endfunction

   // Inputs change on the falling edge; wr_rdy seen there holds for the next rise.
   task automatic arm(input int last);
      @(negedge clk);
      burst_start = 1'b1;
      burst_last  = CNT_W'(last);
      @(negedge clk);
      burst_start = 1'b0;
   endtask

   task automatic drive_words(input int n, input int base, input bit toggle, input bit wide,
                              output int sent, output int rdy_drops);
      int guard = 0;
      bit phase = 1'b0;
      sent = 0;
      rdy_drops = 0;
      while (sent < n && guard < 1000) begin
         @(negedge clk);
         guard++;
         if (wr_rdy !== 1'b1) rdy_drops++;
         if (toggle && phase) wr_val = 1'b0;
         else begin
            wr_val  = 1'b1;
            wr_data = word_of(base + sent, wide);
         end
         if (wr_val && wr_rdy) sent++;
         phase = ~phase;
      end
      @(negedge clk);
      wr_val = 1'b0;
   endtask

   task automatic do_read(input int addr);
      @(negedge clk);
      rd_req  = 1'b1;
      rd_addr = ADDR_W'(addr);
      @(negedge clk);
      rd_req  = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      burst_start = 1'b0; burst_last = '0; burst_abort = 1'b0;
      wr_val = 1'b0; wr_data = '0; rd_req = 1'b0; rd_addr = '0;
      #12;
      checks++;
      if ({wr_rdy, busy, burst_done, len_err, overflow, cmd_err, rd_data_vld} !== 7'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 0000000",
                  {wr_rdy, busy, burst_done, len_err, overflow, cmd_err, rd_data_vld});
      end
      checks++;
      if (word_cnt !== '0 || checksum !== 32'd0 || rd_data !== '0) begin
         errors++;
         $display("FAIL reset_values: word_cnt %0d checksum %h rd_data %h, expected all 0",
                  word_cnt, checksum, rd_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_full_burst;
      int sent, drops;
      @(negedge clk);
      burst_start = 1'b1;
      burst_last  = 10'd63;
      #1;
      checks++;
      if (wr_rdy !== 1'b0) begin
         errors++; $display("FAIL t1_rdy_before_arm: got %b expected 0", wr_rdy);
      end
      @(negedge clk);
      burst_start = 1'b0;
      checks++;
      if (wr_rdy !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL t1_armed: wr_rdy %b busy %b expected 1 1", wr_rdy, busy);
      end
      drive_words(64, 0, 1'b0, 1'b0, sent, drops);
      checks++;
      if (sent !== 64) begin
         errors++; $display("FAIL t1_sent: got %0d expected 64", sent);
      end
      checks++;
      if (burst_done !== 1'b1 || wr_rdy !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL t1_done: burst_done %b wr_rdy %b busy %b expected 1 0 0",
                  burst_done, wr_rdy, busy);
      end
      checks++;
      if (word_cnt !== 10'd64 || checksum !== 32'd2016) begin
         errors++;
         $display("FAIL t1_count: word_cnt %0d checksum %0d expected 64 2016", word_cnt, checksum);
      end
      checks++;
      if ({len_err, overflow, cmd_err} !== 3'b000) begin
         errors++; $display("FAIL t1_flags: got %b expected 000", {len_err, overflow, cmd_err});
      end
      @(negedge clk);
      checks++;
      if (burst_done !== 1'b0) begin
         errors++; $display("FAIL t1_done_pulse: got %b expected 0", burst_done);
      end
      do_read(5);
      checks++;
      if (rd_data_vld !== 1'b1 || rd_data !== 128'd5) begin
         errors++; $display("FAIL t1_read5: vld %b data %h expected 1 5", rd_data_vld, rd_data);
      end
   endtask

   task automatic test_throttled;
      int sent, drops;
      arm(63);
      drive_words(64, 0, 1'b1, 1'b0, sent, drops);
      checks++;
      if (sent !== 64 || drops !== 0) begin
         errors++; $display("FAIL t2_rdy_held: sent %0d rdy drops %0d expected 64 0", sent, drops);
      end
      checks++;
      if (word_cnt !== 10'd64 || checksum !== 32'd2016 || burst_done !== 1'b1) begin
         errors++;
         $display("FAIL t2_count: word_cnt %0d checksum %0d done %b expected 64 2016 1",
                  word_cnt, checksum, burst_done);
      end
   endtask

   task automatic test_overflow;
      int sent, drops;
      arm(99);
      drive_words(100, 0, 1'b0, 1'b0, sent, drops);
      checks++;
      if (word_cnt !== 10'd100 || checksum !== 32'd4950) begin
         errors++;
         $display("FAIL t3_count: word_cnt %0d checksum %0d expected 100 4950", word_cnt, checksum);
      end
      checks++;
      if (overflow !== 1'b1 || len_err !== 1'b0 || burst_done !== 1'b1) begin
         errors++;
         $display("FAIL t3_flags: overflow %b len_err %b done %b expected 1 0 1",
                  overflow, len_err, burst_done);
      end
      do_read(63);
      checks++;
      if (rd_data !== 128'd63) begin
         errors++; $display("FAIL t3_read63: got %h expected 63", rd_data);
      end
      do_read(0);
      checks++;
      if (rd_data !== 128'd0) begin
         errors++; $display("FAIL t3_read0: got %h expected 0", rd_data);
      end
   endtask

   task automatic test_abort;
      int sent, drops;
      arm(63);
      drive_words(10, 0, 1'b0, 1'b1, sent, drops);
      burst_abort = 1'b1;
      @(negedge clk);
      burst_abort = 1'b0;
      checks++;
      if (burst_done !== 1'b1 || busy !== 1'b0 || wr_rdy !== 1'b0) begin
         errors++;
         $display("FAIL t4_done: done %b busy %b wr_rdy %b expected 1 0 0", burst_done, busy, wr_rdy);
      end
      checks++;
      if (word_cnt !== 10'd10 || len_err !== 1'b1 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL t4_len: word_cnt %0d len_err %b overflow %b expected 10 1 0",
                  word_cnt, len_err, overflow);
      end
      checks++;
      if (checksum !== 32'h5609_F62D) begin
         errors++; $display("FAIL t4_checksum: got %h expected 5609f62d", checksum);
      end
      @(negedge clk);
      checks++;
      if (burst_done !== 1'b0) begin
         errors++; $display("FAIL t4_done_pulse: got %b expected 0", burst_done);
      end
      do_read(3);
      checks++;
      if (rd_data !== {32'hFFFF_0000, 32'h00FF_FF00, 32'h1000_0000, 32'd3}) begin
         errors++; $display("FAIL t4_read3: got %h", rd_data);
      end
   endtask

   task automatic test_cmd_err;
      int sent, drops;
      arm(3);
      drive_words(1, 10, 1'b0, 1'b0, sent, drops);
      burst_start = 1'b1;
      burst_last  = 10'd0;
      rd_req      = 1'b1;
      rd_addr     = 6'd1;
      @(negedge clk);
      burst_start = 1'b0;
      rd_req      = 1'b0;
      checks++;
      if (cmd_err !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL t5_cmd_err: cmd_err %b busy %b expected 1 1", cmd_err, busy);
      end
      checks++;
      if (rd_data_vld !== 1'b0 ||
          rd_data !== {32'hFFFF_0000, 32'h00FF_FF00, 32'h1000_0000, 32'd3}) begin
         errors++; $display("FAIL t5_rd_blocked: vld %b data %h expected 0, data held", rd_data_vld, rd_data);
      end
      drive_words(3, 11, 1'b0, 1'b0, sent, drops);
      checks++;
      if (burst_done !== 1'b1 || word_cnt !== 10'd4 || checksum !== 32'd46 || len_err !== 1'b0) begin
         errors++;
         $display("FAIL t5_burst: done %b word_cnt %0d checksum %0d len_err %b expected 1 4 46 0",
                  burst_done, word_cnt, checksum, len_err);
      end
   endtask

   task automatic test_reset_mid_burst;
      int sent, drops;
      arm(63);
      drive_words(5, 0, 1'b0, 1'b0, sent, drops);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({wr_rdy, busy, cmd_err, rd_data_vld} !== 4'b0 || word_cnt !== '0 ||
          checksum !== 32'd0 || rd_data !== '0) begin
         errors++;
         $display("FAIL t6_async_reset: rdy %b busy %b cmd_err %b cnt %0d chk %h rd %h expected zeros",
                  wr_rdy, busy, cmd_err, word_cnt, checksum, rd_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      arm(0);
      drive_words(1, 7, 1'b0, 1'b0, sent, drops);
      checks++;
      if (burst_done !== 1'b1 || word_cnt !== 10'd1 || checksum !== 32'd7 || wr_rdy !== 1'b0) begin
         errors++;
         $display("FAIL t6_one_word: done %b word_cnt %0d checksum %0d wr_rdy %b expected 1 1 7 0",
                  burst_done, word_cnt, checksum, wr_rdy);
      end
   endtask

   initial begin
      test_reset();
      test_full_burst();
      test_throttled();
      test_overflow();
      test_abort();
      test_cmd_err();
      test_reset_mid_burst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
